// File: rtl/preadder_pipe.sv
// Two-stage pipelined pre-adder alignment: exponent compare/route, then align-shift
// with sticky, magnitude order and sign assignment, under a valid/ready handshake.
module preadder_pipe #(
  parameter int EXP_W  = 8,
  parameter int MAN_W  = 28,
  parameter int SUB_EN = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op_sub,
  input  logic             sign_A,
  input  logic             sign_B,
  input  logic [EXP_W-1:0] exp_A,
  input  logic [EXP_W-1:0] exp_B,
  input  logic [MAN_W-1:0] mantis_A,
  input  logic [MAN_W-1:0] mantis_B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             sign_of_great,
  output logic             sign_of_small,
  output logic [EXP_W-1:0] exp,
  output logic [MAN_W-1:0] mantis_great,
  output logic [MAN_W-1:0] mantis_small,
  output logic             eff_sub,
  output logic             sticky,
  output logic             tie
);

  logic             s1_valid;
  logic [EXP_W-1:0] s1_exp;
  logic [EXP_W:0]   s1_diff;
  logic             s1_sign_sh, s1_sign_ns;
  logic [MAN_W-1:0] s1_man_sh, s1_man_ns;

  logic s2_advance, s1_advance, accept;
  logic sub_en_l, sign_b_eff, a_larger;
  logic [EXP_W:0] diff_ab, diff_ba;

  assign s2_advance = !out_valid | out_ready;
  assign s1_advance = s2_advance;
  assign in_ready   = !s1_valid | s1_advance;
  assign accept     = in_valid & in_ready;

  assign sub_en_l   = (SUB_EN != 0);
  assign sign_b_eff = sign_B ^ (op_sub & sub_en_l);
  assign a_larger   = exp_A > exp_B;
  assign diff_ab    = {1'b0, exp_A} - {1'b0, exp_B};
  assign diff_ba    = {1'b0, exp_B} - {1'b0, exp_A};

  // Stage 1: B is the shift source unless A has the strictly smaller exponent
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_exp     <= '0;
      s1_diff    <= '0;
      s1_sign_sh <= 1'b0;
      s1_sign_ns <= 1'b0;
      s1_man_sh  <= '0;
      s1_man_ns  <= '0;
    end else begin
      if (in_ready) s1_valid <= in_valid;
      if (accept) begin
        if (a_larger || exp_A == exp_B) begin
          s1_exp     <= exp_A;
          s1_diff    <= diff_ab;
          s1_sign_ns <= sign_A;
          s1_man_ns  <= mantis_A;
          s1_sign_sh <= sign_b_eff;
          s1_man_sh  <= mantis_B;
        end else begin
          s1_exp     <= exp_B;
          s1_diff    <= diff_ba;
          s1_sign_ns <= sign_b_eff;
          s1_man_ns  <= mantis_B;
          s1_sign_sh <= sign_A;
          s1_man_sh  <= mantis_A;
        end
      end
    end
  end

  logic [MAN_W-1:0] shifted;
  logic             nxt_sticky;
  logic [MAN_W-1:0] nxt_great, nxt_small;
  logic             nxt_sg, nxt_ss, nxt_tie;

  always_comb begin
    nxt_sticky = 1'b0;
    for (int unsigned i = 0; i < MAN_W; i++) begin
      if (i < 32'(s1_diff)) nxt_sticky = nxt_sticky | s1_man_sh[i];
    end
    if (32'(s1_diff) >= 32'(MAN_W)) shifted = '0;
    else                            shifted = s1_man_sh >> s1_diff;
  end

  // Ties with opposite signs put the positive operand on top so cancellation gives +0
  always_comb begin
    nxt_tie   = 1'b0;
    nxt_great = s1_man_ns;
    nxt_small = shifted;
    nxt_sg    = s1_sign_ns;
    nxt_ss    = s1_sign_sh;
    if (shifted > s1_man_ns) begin
      nxt_great = shifted;
      nxt_small = s1_man_ns;
      nxt_sg    = s1_sign_sh;
      nxt_ss    = s1_sign_ns;
    end else if (shifted == s1_man_ns) begin
      nxt_tie = 1'b1;
      if (s1_sign_sh != s1_sign_ns) begin
        nxt_sg = 1'b0;
        nxt_ss = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      sign_of_great <= 1'b0;
      sign_of_small <= 1'b0;
      exp           <= '0;
      mantis_great  <= '0;
      mantis_small  <= '0;
      eff_sub       <= 1'b0;
      sticky        <= 1'b0;
      tie           <= 1'b0;
    end else if (s2_advance) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        sign_of_great <= nxt_sg;
        sign_of_small <= nxt_ss;
        exp           <= s1_exp;
        mantis_great  <= nxt_great;
        mantis_small  <= nxt_small;
        eff_sub       <= nxt_sg ^ nxt_ss;
        sticky        <= nxt_sticky;
        tie           <= nxt_tie;
      end
    end
  end

endmodule

// File: tb/tb_preadder_pipe.sv
// Directed self-checking bench for preadder_pipe with default parameters.
module tb_preadder_pipe;
  localparam int EXP_W = 8;
  localparam int MAN_W = 28;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0, in_ready;
  logic             op_sub = 1'b0, sign_A = 1'b0, sign_B = 1'b0;
  logic [EXP_W-1:0] exp_A = '0, exp_B = '0;
  logic [MAN_W-1:0] mantis_A = '0, mantis_B = '0;
  logic             out_valid, out_ready = 1'b1;
  logic             sign_of_great, sign_of_small, eff_sub, sticky, tie;
  logic [EXP_W-1:0] exp;
  logic [MAN_W-1:0] mantis_great, mantis_small;

  int checks = 0;
  int errors = 0;

  preadder_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W), .SUB_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op_sub(op_sub), .sign_A(sign_A), .sign_B(sign_B), .exp_A(exp_A), .exp_B(exp_B),
    .mantis_A(mantis_A), .mantis_B(mantis_B), .out_valid(out_valid), .out_ready(out_ready),
    .sign_of_great(sign_of_great), .sign_of_small(sign_of_small), .exp(exp),
    .mantis_great(mantis_great), .mantis_small(mantis_small), .eff_sub(eff_sub),
    .sticky(sticky), .tie(tie)
  );

  always #5 clk = ~clk;

  task automatic set_ops(input logic sa, input logic [EXP_W-1:0] ea, input logic [MAN_W-1:0] ma,
                         input logic sb, input logic [EXP_W-1:0] eb, input logic [MAN_W-1:0] mb,
                         input logic sub);
    sign_A = sa; exp_A = ea; mantis_A = ma;
    sign_B = sb; exp_B = eb; mantis_B = mb;
    op_sub = sub;
  endtask

  // Presents one operand pair for a cycle, then waits (bounded) for its result.
  task automatic send_wait();
    int n = 0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    while (!out_valid && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++; $display("FAIL send_wait_timeout out_valid=%b want 1", out_valid);
    end
  endtask

  task automatic test_reset();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || exp !== '0 || mantis_great !== '0 ||
        mantis_small !== '0 || sticky !== 1'b0 || tie !== 1'b0 || eff_sub !== 1'b0) begin
      errors++;
      $display("FAIL reset_state ov=%b ir=%b exp=%h mg=%h ms=%h st=%b tie=%b es=%b want 0/1/0...",
               out_valid, in_ready, exp, mantis_great, mantis_small, sticky, tie, eff_sub);
    end
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    set_ops(1'b0, 8'h80, 28'h8000000, 1'b0, 8'h7E, 28'hC000000, 1'b0);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL latency_1 out_valid=%b want 0", out_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1) begin
      errors++; $display("FAIL latency_2 out_valid=%b want 1", out_valid);
    end
    checks++;
    if (exp !== 8'h80 || mantis_great !== 28'h8000000 || mantis_small !== 28'h3000000 ||
        sticky !== 1'b0 || eff_sub !== 1'b0 || tie !== 1'b0) begin
      errors++;
      $display("FAIL basic exp=%h mg=%h ms=%h st=%b es=%b tie=%b want 80 8000000 3000000 0 0 0",
               exp, mantis_great, mantis_small, sticky, eff_sub, tie);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL single_emit out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_big_shift();
    set_ops(1'b0, 8'h90, 28'h8000000, 1'b0, 8'h60, 28'h0000001, 1'b0);
    send_wait();
    checks++;
    if (mantis_small !== '0 || sticky !== 1'b1 || exp !== 8'h90 || mantis_great !== 28'h8000000) begin
      errors++;
      $display("FAIL big_shift ms=%h st=%b exp=%h mg=%h want 0 1 90 8000000",
               mantis_small, sticky, exp, mantis_great);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_tie_cancel();
    set_ops(1'b0, 8'h80, 28'h4000000, 1'b0, 8'h80, 28'h4000000, 1'b1);
    send_wait();
    checks++;
    if (tie !== 1'b1 || eff_sub !== 1'b1 || sign_of_great !== 1'b0 || sign_of_small !== 1'b1 ||
        mantis_great !== 28'h4000000 || mantis_small !== 28'h4000000) begin
      errors++;
      $display("FAIL tie_cancel tie=%b es=%b sg=%b ss=%b mg=%h ms=%h want 1 1 0 1 4000000 4000000",
               tie, eff_sub, sign_of_great, sign_of_small, mantis_great, mantis_small);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_swap();
    set_ops(1'b1, 8'h85, 28'h1000000, 1'b0, 8'h85, 28'h2000000, 1'b0);
    send_wait();
    checks++;
    if (mantis_great !== 28'h2000000 || mantis_small !== 28'h1000000 || sign_of_great !== 1'b0 ||
        sign_of_small !== 1'b1 || eff_sub !== 1'b1 || tie !== 1'b0 || exp !== 8'h85) begin
      errors++;
      $display("FAIL swap mg=%h ms=%h sg=%b ss=%b es=%b tie=%b exp=%h want 2000000 1000000 0 1 1 0 85",
               mantis_great, mantis_small, sign_of_great, sign_of_small, eff_sub, tie, exp);
    end
    @(posedge clk); #1;
  endtask

  // Item i: A=(+,0x80+i,0x8000000), B=(+,0x80,0x8000000) -> small = 0x8000000>>i, tie only at i=0.
  task automatic test_back_to_back();
    int sent = 0, got = 0, occ = 0, cyc = 0;
    logic acc, emi, stalled = 1'b0;
    logic [EXP_W-1:0] h_exp = '0;
    logic [MAN_W-1:0] h_small = '0;
    logic [MAN_W-1:0] e_small;
    logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    while (got < 8 && cyc < 200) begin
      in_valid = (sent < 8);
      set_ops(1'b0, 8'(8'h80 + sent), 28'h8000000, 1'b0, 8'h80, 28'h8000000, 1'b0);
      out_ready = pat[cyc % 4];
      @(negedge clk);
      checks++;
      if (in_ready !== !(occ == 2 && !out_ready)) begin
        errors++; $display("FAIL b2b_in_ready cyc=%0d got=%b want %b", cyc, in_ready, !(occ == 2 && !out_ready));
      end
      if (stalled) begin
        checks++;
        if (out_valid !== 1'b1 || exp !== h_exp || mantis_small !== h_small) begin
          errors++;
          $display("FAIL b2b_hold cyc=%0d ov=%b exp=%h ms=%h want 1 %h %h", cyc, out_valid, exp, mantis_small, h_exp, h_small);
        end
      end
      if (out_valid && out_ready) begin
        e_small = 28'h8000000 >> got;
        checks++;
        if (exp !== 8'(8'h80 + got) || mantis_great !== 28'h8000000 || mantis_small !== e_small ||
            tie !== (got == 0) || sticky !== 1'b0) begin
          errors++;
          $display("FAIL b2b_data idx=%0d exp=%h mg=%h ms=%h tie=%b st=%b want %h 8000000 %h %b 0",
                   got, exp, mantis_great, mantis_small, tie, sticky, 8'(8'h80 + got), e_small, got == 0);
        end
      end
      acc = in_valid && in_ready;
      emi = out_valid && out_ready;
      stalled = out_valid && !out_ready;
      h_exp = exp;
      h_small = mantis_small;
      @(posedge clk); #1;
      if (acc) begin sent++; occ++; end
      if (emi) begin got++; occ--; end
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (got != 8) begin
      errors++; $display("FAIL b2b_count got=%0d want 8", got);
    end
  endtask

  task automatic test_mid_reset();
    out_ready = 1'b0;
    set_ops(1'b0, 8'h81, 28'h8000000, 1'b0, 8'h80, 28'h8000000, 1'b0);
    in_valid = 1'b1;
    @(posedge clk); #1;
    set_ops(1'b0, 8'h82, 28'h8000000, 1'b0, 8'h80, 28'h8000000, 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      errors++; $display("FAIL mid_reset_setup ov=%b ir=%b want 1 0", out_valid, in_ready);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || exp !== '0) begin
      errors++; $display("FAIL mid_reset_async ov=%b exp=%h want 0 0", out_valid, exp);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++; $display("FAIL mid_reset_stale cyc=%0d ov=%b want 0", i, out_valid);
      end
    end
  endtask

  initial begin
    #12;
    test_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_basic();
    test_big_shift();
    test_tie_cancel();
    test_swap();
    test_back_to_back();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/preadder_pipe.md
Name: preadder_pipe

Overview:
- Parametrised, pipelined successor of the combinational pre-adder alignment stage in the floating-point adder datapath.
- Takes two unpacked operands. Selects the larger exponent and right-shifts the smaller-exponent mantissa, accumulating a sticky bit.
- Orders the aligned mantissas by magnitude and emits great/small mantissas, their signs, the common exponent and flags.
- Sits between operand unpack and the mantissa adder. Two register stages with a valid/ready handshake allow back-pressure from the adder.

Parameters:
- EXP_W, 8, exponent width in bits.
- MAN_W, 28, mantissa width in bits (hidden, guard and round bits included, MSB-aligned).
- SUB_EN, 1, 1 = op_sub input honoured; 0 = op_sub ignored (add only).

Ports:
- clk  in  1  clock, all state on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept the operand pair this cycle.
- op_sub  in  1  1 = compute A-B (sign_B inverted internally).
- sign_A, sign_B  in  1 each  operand signs.
- exp_A, exp_B  in  EXP_W each  biased exponents.
- mantis_A, mantis_B  in  MAN_W each  mantissas.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- sign_of_great, sign_of_small  out  1 each  signs of the larger/smaller magnitude operand.
- exp  out  EXP_W  common (larger) exponent.
- mantis_great, mantis_small  out  MAN_W each  aligned mantissas, mantis_great >= mantis_small.
- eff_sub  out  1  effective subtraction (sign_of_great != sign_of_small).
- sticky  out  1  OR of all bits shifted out of the smaller mantissa.
- tie  out  1  aligned mantissas exactly equal.

Behaviour:
- Reset (async assert, sync release): out_valid=0, all data outputs=0, both stage valids=0, in_ready=1 after release.
- Effective sign_B is sign_B ^ (op_sub & SUB_EN), applied at capture.
- Stage 1 (capture on in_valid & in_ready), registered:
  - exponent compare; exp = max(exp_A, exp_B).
  - diff = |exp_A - exp_B|, computed in EXP_W+1 bits with no wrap.
  - shift source = the smaller-exponent operand; on equal exponents, B is the shift source with diff=0.
  - both signs and both mantissas routed to shift/non-shift lanes.
- Stage 2, registered:
  - shifted = shift-lane mantissa >> diff; sticky = OR of the bits dropped.
  - If diff >= MAN_W: shifted=0 and sticky = |mantissa.
  - Magnitude compare of shifted vs. non-shift lanes, then swap so mantis_great >= mantis_small. Signs and eff_sub follow the swap.
- Tie rule (equal aligned mantissas): tie=1.
  - Equal signs: non-shift lane is great.
  - Different signs: the positive operand is great (sign_of_great=0), so an exact cancellation yields +0.
- Handshake:
  - Each stage holds a valid bit. Stage 2 advances when !out_valid | out_ready; stage 1 advances when stage 2 is empty or advancing.
  - in_ready = !s1_valid | s1_advance (combinational, no combinational path from in_valid).
  - Output registers and out_valid hold stable while out_valid & !out_ready.
  - Latency is 2 cycles from accept to out_valid with out_ready held high; throughput is 1 per cycle.
  - No operand is dropped or duplicated under any out_ready pattern.
- Simultaneous accept and emit in the same cycle is legal and keeps full throughput.
- Reset mid-operation: all in-flight results are discarded; out_valid=0 on the next edge.
- Zero or denormal handling is upstream. Zero mantissas flow through with no special casing.

Test Plan:
- Defaults, A=(+, 0x80, 0x8000000), B=(+, 0x7E, 0xC000000), out_ready=1 -> 2 cycles later: exp=0x80, mantis_great=0x8000000, mantis_small=0x3000000, sticky=0, eff_sub=0, tie=0.
- exp_A=0x90, exp_B=0x60 (diff 48 >= 28), mantis_B=0x0000001 -> mantis_small=0, sticky=1, exp=0x90.
- A=(+, 0x80, 0x4000000), B=(+, 0x80, 0x4000000), op_sub=1 -> tie=1, eff_sub=1, sign_of_great=0, sign_of_small=1.
- Equal exponents, mantis_A=0x1000000 < mantis_B=0x2000000, sign_A=1, sign_B=0 -> mantis_great=0x2000000, sign_of_great=0, sign_of_small=1.
- Stream of 8 back-to-back operands with out_ready toggling 1,0,0,1,... -> in_ready drops only when both stages are full; the 8 results emerge in order, unchanged while stalled.
- Assert rst_n=0 for 1 cycle with 2 results in flight -> out_valid=0 immediately; no stale result appears after release.
